// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the EX-stage branch resolution controller.
package branch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    FLUSH     = 2'd2
  } state_e;

endpackage

// File: rtl/branch_comparator.sv
// Conditional-branch compare; codes 010/011 are reserved and never taken.
module branch_comparator
  import branch_ctrl_pkg::*;
(
  input  logic            is_branch,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    unique case (branch_type)
      F3_BEQ:  cond = (op1 == op2);
      F3_BNE:  cond = (op1 != op2);
      F3_BLT:  cond = ($signed(op1) <  $signed(op2));
      F3_BGE:  cond = ($signed(op1) >= $signed(op2));
      F3_BLTU: cond = (op1 <  op2);
      F3_BGEU: cond = (op1 >= op2);
      default: cond = 1'b0;
    endcase
  end

  assign taken = is_branch & cond;

endmodule

// File: rtl/branch_ctrl.sv
// Resolves EX-stage branches: zero-latency redirect/flush on mispredict,
// stall while operands are pending, saturating performance counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_branch_type,
  input  logic [XLEN-1:0]  ex_operand1,
  input  logic [XLEN-1:0]  ex_operand2,
  input  logic             ex_operands_ready,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;
  logic             br_valid, taken, mispredict;
  logic             inc_branch, inc_mispredict;
  logic             redirect_d, flush_d, stall_d;
  logic [XLEN-1:0]  target;

  assign br_valid = ex_valid & ex_is_branch;

  branch_comparator u_cmp (
    .is_branch   (br_valid),
    .branch_type (ex_branch_type),
    .op1         (ex_operand1),
    .op2         (ex_operand2),
    .taken       (taken)
  );

  assign mispredict = taken ^ ex_pred_taken;
  assign target     = (taken ? (ex_pc + ex_imm) : (ex_pc + PC_INC)) & ~XLEN'(1);

  // Next state and strobes; FLUSH ignores EX inputs entirely.
  always_comb begin
    state_d        = state_q;
    redirect_d     = 1'b0;
    flush_d        = 1'b0;
    stall_d        = 1'b0;
    inc_branch     = 1'b0;
    inc_mispredict = 1'b0;
    unique case (state_q)
      IDLE, WAIT_OPND: begin
        if (br_valid && ex_operands_ready) begin
          inc_branch = 1'b1;
          if (mispredict) begin
            redirect_d     = 1'b1;
            flush_d        = 1'b1;
            inc_mispredict = 1'b1;
            state_d        = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end else if (br_valid) begin
          stall_d = 1'b1;
          state_d = WAIT_OPND;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes read zero during the reset cycle.
  assign redirect    = redirect_d & ~rst;
  assign flush       = flush_d & ~rst;
  assign stall       = stall_d & ~rst;
  assign redirect_pc = rst ? '0 : target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (inc_branch && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (inc_mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; narrow counters so saturation is reachable.
module tb_branch_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_is_branch, ex_operands_ready, ex_pred_taken;
  logic [2:0]       ex_branch_type;
  logic [31:0]      ex_operand1, ex_operand2, ex_pc, ex_imm;
  logic             redirect, flush, stall;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid          (ex_valid),
    .ex_is_branch      (ex_is_branch),
    .ex_branch_type    (ex_branch_type),
    .ex_operand1       (ex_operand1),
    .ex_operand2       (ex_operand2),
    .ex_operands_ready (ex_operands_ready),
    .ex_pred_taken     (ex_pred_taken),
    .ex_pc             (ex_pc),
    .ex_imm            (ex_imm),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .flush             (flush),
    .stall             (stall),
    .branch_cnt        (branch_cnt),
    .mispredict_cnt    (mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic r, input logic f, input logic s);
    chk({tag, ".redirect"}, 32'(redirect), 32'(r));
    chk({tag, ".flush"},    32'(flush),    32'(f));
    chk({tag, ".stall"},    32'(stall),    32'(s));
  endtask

  task automatic counts(input string tag, input int bc, input int mc);
    chk({tag, ".branch_cnt"},     32'(branch_cnt),     32'(bc));
    chk({tag, ".mispredict_cnt"}, 32'(mispredict_cnt), 32'(mc));
  endtask

  // Advance to the next falling edge, then apply a branch.
  task automatic br(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] b,
                    input logic rdy, input logic pred, input logic [31:0] pc,
                    input logic [31:0] imm);
    @(negedge clk);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_branch_type = ty;
    ex_operand1 = a; ex_operand2 = b; ex_operands_ready = rdy;
    ex_pred_taken = pred; ex_pc = pc; ex_imm = imm;
    #2;
  endtask

  task automatic idle();
    @(negedge clk);
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_operands_ready = 1'b0;
    ex_pred_taken = 1'b0;
    #2;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_branch_type = 3'b000;
    ex_operand1 = '0; ex_operand2 = '0; ex_operands_ready = 1'b0;
    ex_pred_taken = 1'b0; ex_pc = '0; ex_imm = '0;

    // Mispredicting branch held during reset: strobes and redirect_pc stay 0
    br(3'b000, 32'h5, 32'h5, 1'b1, 1'b0, 32'h100, 32'h20);
    strobes("rst_cycle", 1'b0, 1'b0, 1'b0);
    chk("rst_cycle.redirect_pc", redirect_pc, 32'h0);
    idle();
    counts("after_rst", 0, 0);
    rst = 1'b0;

    // beq taken, predicted not-taken
    br(3'b000, 32'h5, 32'h5, 1'b1, 1'b0, 32'h100, 32'h20);
    strobes("beq_mp", 1'b1, 1'b1, 1'b0);
    chk("beq_mp.redirect_pc", redirect_pc, 32'h120);
    // FLUSH cycle with a valid mispredicting branch presented: ignored
    br(3'b000, 32'h5, 32'h5, 1'b1, 1'b0, 32'h100, 32'h20);
    strobes("flush_cycle", 1'b0, 1'b0, 1'b0);
    counts("flush_cycle", 1, 1);
    idle();
    strobes("post_flush", 1'b0, 1'b0, 1'b0);
    counts("post_flush", 1, 1);

    // blt signed: -1 < 1 taken, predicted taken
    br(3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h200, 32'h40);
    strobes("blt_ok", 1'b0, 1'b0, 1'b0);
    // bltu: 0xFFFFFFFF < 1 false, predicted taken -> fall-through redirect
    br(3'b110, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h200, 32'h40);
    counts("blt_ok", 2, 1);
    strobes("bltu_mp", 1'b1, 1'b1, 1'b0);
    chk("bltu_mp.redirect_pc", redirect_pc, 32'h204);
    idle();
    counts("bltu_mp", 3, 2);

    // bge 3 >= 7 false, predicted not-taken; operands late for 3 cycles
    for (int i = 0; i < 3; i++) begin
      br(3'b101, 32'h3, 32'h7, 1'b0, 1'b0, 32'h280, 32'h8);
      strobes($sformatf("wait%0d", i), 1'b0, 1'b0, 1'b1);
    end
    br(3'b101, 32'h3, 32'h7, 1'b1, 1'b0, 32'h280, 32'h8);
    strobes("wait_resolve", 1'b0, 1'b0, 1'b0);
    idle();
    counts("wait_resolve", 4, 2);

    // Branch abandoned while waiting: no count
    br(3'b000, 32'h1, 32'h1, 1'b0, 1'b1, 32'h2C0, 32'h8);
    strobes("abandon_wait", 1'b0, 1'b0, 1'b1);
    idle();
    strobes("abandon_drop", 1'b0, 1'b0, 1'b0);
    idle();
    counts("abandon", 4, 2);

    // bne taken with odd immediate: bit 0 cleared
    br(3'b001, 32'h1, 32'h2, 1'b1, 1'b0, 32'h300, 32'h11);
    strobes("bne_mp", 1'b1, 1'b1, 1'b0);
    chk("bne_mp.redirect_pc", redirect_pc, 32'h310);
    idle();
    counts("bne_mp", 5, 3);

    // Reserved code 010 never taken
    br(3'b010, 32'h9, 32'h9, 1'b1, 1'b1, 32'h400, 32'h80);
    strobes("rsvd_mp", 1'b1, 1'b1, 1'b0);
    chk("rsvd_mp.redirect_pc", redirect_pc, 32'h404);
    idle();
    counts("rsvd_mp", 6, 4);

    // bgeu 5 >= 5 taken, predicted taken
    br(3'b111, 32'h5, 32'h5, 1'b1, 1'b1, 32'h500, 32'h10);
    strobes("bgeu_ok", 1'b0, 1'b0, 1'b0);
    idle();
    counts("bgeu_ok", 7, 4);

    // PC wraparound on fall-through; drive counters into saturation
    for (int i = 0; i < 14; i++) begin
      br(3'b000, 32'h1, 32'h2, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40);
      chk($sformatf("wrap%0d.redirect", i), 32'(redirect), 32'h1);
      chk($sformatf("wrap%0d.redirect_pc", i), redirect_pc, 32'h0);
      idle();
    end
    counts("saturated", 15, 15);
    br(3'b000, 32'h1, 32'h2, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40);
    idle();
    counts("sat_hold", 15, 15);

    // Reset while in WAIT_OPND
    br(3'b000, 32'h1, 32'h1, 1'b0, 1'b0, 32'h600, 32'h8);
    strobes("pre_rst_wait", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    strobes("rst_in_wait", 1'b0, 1'b0, 1'b0);
    idle();
    rst = 1'b0;
    #1;
    strobes("post_rst", 1'b0, 1'b0, 1'b0);
    counts("post_rst", 0, 0);
    // Back in IDLE: a correctly predicted branch resolves immediately
    br(3'b000, 32'h1, 32'h1, 1'b1, 1'b1, 32'h700, 32'h8);
    strobes("post_rst_br", 1'b0, 1'b0, 1'b0);
    idle();
    counts("post_rst_br", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
